// File: rtl/axi_master_bridge.sv
// Bridges a single-outstanding CPU memory request port onto AXI4: reads become
// INCR bursts of req_len+1 beats, writes become single-beat AW/W/B transactions.
module axi_master_bridge #(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic [3:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [3:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [3:0]  AWID,
  output logic [31:0] AWADDR,
  output logic [3:0]  AWLEN,
  output logic [2:0]  AWSIZE,
  output logic [1:0]  AWBURST,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WLAST,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [3:0]  BID,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t      state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [3:0]  len_q, len_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [3:0]  beat_q, beat_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        req_ready_q, req_ready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_last_q, rsp_last_d;
  logic        rsp_err_q, rsp_err_d;
  logic        aw_hs, w_hs;
  logic        unused_ok;

  // A beat is in error on a bad response, or when RLAST disagrees with the
  // beat count the burst length implies.
  function automatic logic beat_err(input logic [1:0] resp, input logic last,
                                    input logic [3:0] cnt, input logic [3:0] len);
    beat_err = (resp != 2'b00) || (last && (cnt != len)) || (!last && (cnt == len));
  endfunction

  assign aw_hs = awvalid_q & AWREADY;
  assign w_hs  = wvalid_q & WREADY;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    beat_d      = beat_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    req_ready_d = req_ready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = 1'b0;
    rsp_err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d      = req_addr[31:2];
          len_d       = req_len;
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          beat_d      = 4'd0;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          req_ready_d = 1'b0;
          if (req_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      RD_ADDR: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (RVALID) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = RDATA;
          rsp_last_d  = RLAST;
          rsp_err_d   = beat_err(RRESP, RLAST, beat_q, len_q);
          beat_d      = beat_q + 4'd1;
          if (RLAST) begin
            rready_d    = 1'b0;
            req_ready_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Either channel may complete first, or both in the same cycle.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BVALID) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'd0;
          rsp_last_d  = 1'b1;
          rsp_err_d   = (BRESP != 2'b00);
          bready_d    = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      beat_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      req_ready_q <= 1'b1;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      beat_q      <= beat_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      req_ready_q <= req_ready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Payloads read as zero whenever their channel is idle, stable while VALID.
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;

  assign ARVALID = arvalid_q;
  assign ARID    = arvalid_q ? MASTER_ID : 4'd0;
  assign ARADDR  = arvalid_q ? {addr_q, 2'b00} : 32'd0;
  assign ARLEN   = arvalid_q ? len_q : 4'd0;
  assign ARSIZE  = arvalid_q ? 3'b010 : 3'b000;
  assign ARBURST = arvalid_q ? 2'b01 : 2'b00;
  assign RREADY  = rready_q;

  assign AWVALID = awvalid_q;
  assign AWID    = awvalid_q ? MASTER_ID : 4'd0;
  assign AWADDR  = awvalid_q ? {addr_q, 2'b00} : 32'd0;
  assign AWLEN   = 4'd0;
  assign AWSIZE  = awvalid_q ? 3'b010 : 3'b000;
  assign AWBURST = awvalid_q ? 2'b01 : 2'b00;

  assign WVALID  = wvalid_q;
  assign WDATA   = wvalid_q ? wdata_q : 32'd0;
  assign WSTRB   = wvalid_q ? wstrb_q : 4'd0;
  assign WLAST   = wvalid_q;
  assign BREADY  = bready_q;

  assign unused_ok = ^{RID, BID, req_addr[1:0]};

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed bench for axi_master_bridge: the bench plays both the CPU and a
// scripted AXI slave, stepping on falling edges with hand-computed expectations.
module tb_axi_master_bridge;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_len, req_wstrb;
  logic        rsp_valid, rsp_last, rsp_err;
  logic [31:0] rsp_data;
  logic [3:0]  ARID, ARLEN, RID, AWID, AWLEN, WSTRB, BID;
  logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
  logic [2:0]  ARSIZE, AWSIZE;
  logic [1:0]  ARBURST, RRESP, AWBURST, BRESP;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

  int total = 0;
  int bad   = 0;

  always #5 ACLK = ~ACLK;

  axi_master_bridge #(.MASTER_ID(4'd0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] l,
                       input logic [31:0] d, input logic [3:0] s);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l;
    req_wdata = d; req_wstrb = s;
    @(negedge ACLK);
    req_valid = 1'b0; req_write = 1'b0;
    chk("req_ready_busy", req_ready, 0);
  endtask

  task automatic ar_accept(input logic [31:0] exp_addr, input logic [3:0] exp_len);
    chk("arvalid", ARVALID, 1);
    chk("araddr", ARADDR, exp_addr);
    chk("arlen", ARLEN, exp_len);
    ARREADY = 1'b1;
    @(negedge ACLK);
    ARREADY = 1'b0;
    chk("arvalid_drop", ARVALID, 0);
    chk("rready", RREADY, 1);
  endtask

  task automatic beat(input string tag, input logic [31:0] d, input logic last,
                      input logic [1:0] resp, input logic exp_err);
    RVALID = 1'b1; RDATA = d; RLAST = last; RRESP = resp;
    @(negedge ACLK);
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_data"}, rsp_data, d);
    chk({tag, "_last"}, rsp_last, last);
    chk({tag, "_err"}, rsp_err, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] bdat [4];
    bdat[0] = 32'h1111_0000; bdat[1] = 32'h2222_0001;
    bdat[2] = 32'h3333_0002; bdat[3] = 32'h4444_0003;
    ARESETn = 1'b0;
    req_valid = 0; req_write = 0; req_addr = 0; req_len = 0; req_wdata = 0; req_wstrb = 0;
    ARREADY = 0; RID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RVALID = 0;
    AWREADY = 0; WREADY = 0; BID = 0; BRESP = 0; BVALID = 0;
    repeat (2) @(negedge ACLK);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_rready", RREADY, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_arsize", ARSIZE, 0);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // Single read, unaligned address
    issue(1'b0, 32'h0000_1006, 4'd0, 32'd0, 4'd0);
    chk("t1_arsize", ARSIZE, 3'b010);
    chk("t1_arburst", ARBURST, 2'b01);
    chk("t1_arid", ARID, 0);
    ar_accept(32'h0000_1004, 4'd0);
    beat("t1", 32'hDEAD_BEEF, 1'b1, 2'b00, 1'b0);
    chk("t1_req_ready", req_ready, 1);
    @(negedge ACLK);
    chk("t1_rsp_pulse", rsp_valid, 0);

    // Burst of 4 with delayed ARREADY and 2-cycle gaps between beats
    issue(1'b0, 32'h0000_2000, 4'd3, 32'd0, 4'd0);
    @(negedge ACLK);
    chk("t2_ar_hold_valid", ARVALID, 1);
    chk("t2_ar_hold_addr", ARADDR, 32'h0000_2000);
    ar_accept(32'h0000_2000, 4'd3);
    for (int i = 0; i < 4; i++) begin
      beat($sformatf("t2_b%0d", i), bdat[i], (i == 3), 2'b00, 1'b0);
      @(negedge ACLK);
      chk("t2_gap", rsp_valid, 0);
      if (i < 3) @(negedge ACLK);
    end
    chk("t2_req_ready", req_ready, 1);

    // Write where W completes three cycles before AW
    issue(1'b1, 32'h0000_3008, 4'd0, 32'h1234_5678, 4'b0011);
    chk("t3_awvalid", AWVALID, 1);
    chk("t3_wvalid", WVALID, 1);
    chk("t3_awaddr", AWADDR, 32'h0000_3008);
    chk("t3_awlen", AWLEN, 0);
    chk("t3_wdata", WDATA, 32'h1234_5678);
    chk("t3_wstrb", WSTRB, 4'b0011);
    chk("t3_wlast", WLAST, 1);
    WREADY = 1'b1;
    @(negedge ACLK);
    WREADY = 1'b0;
    chk("t3_wvalid_drop", WVALID, 0);
    chk("t3_awvalid_held", AWVALID, 1);
    @(negedge ACLK);
    chk("t3_awvalid_held2", AWVALID, 1);
    chk("t3_no_bready", BREADY, 0);
    @(negedge ACLK);
    AWREADY = 1'b1;
    @(negedge ACLK);
    AWREADY = 1'b0;
    chk("t3_awvalid_drop", AWVALID, 0);
    chk("t3_bready", BREADY, 1);
    BVALID = 1'b1; BRESP = 2'b00;
    @(negedge ACLK);
    BVALID = 1'b0;
    chk("t3_rsp_valid", rsp_valid, 1);
    chk("t3_rsp_last", rsp_last, 1);
    chk("t3_rsp_err", rsp_err, 0);
    chk("t3_rsp_data", rsp_data, 0);
    chk("t3_req_ready", req_ready, 1);

    // Write with simultaneous AW/W handshake and SLVERR
    issue(1'b1, 32'h0000_3010, 4'd0, 32'hCAFE_F00D, 4'b1111);
    AWREADY = 1'b1; WREADY = 1'b1;
    @(negedge ACLK);
    AWREADY = 1'b0; WREADY = 1'b0;
    chk("t4_awvalid_drop", AWVALID, 0);
    chk("t4_wvalid_drop", WVALID, 0);
    chk("t4_bready", BREADY, 1);
    BVALID = 1'b1; BRESP = 2'b10;
    @(negedge ACLK);
    BVALID = 1'b0; BRESP = 2'b00;
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_rsp_last", rsp_last, 1);
    chk("t4_rsp_err", rsp_err, 1);

    // Early RLAST on beat index 2 of a 4-beat burst
    issue(1'b0, 32'h0000_4000, 4'd3, 32'd0, 4'd0);
    ar_accept(32'h0000_4000, 4'd3);
    beat("t5_b0", 32'hA0A0_0000, 1'b0, 2'b00, 1'b0);
    beat("t5_b1", 32'hA0A0_0001, 1'b0, 2'b00, 1'b0);
    beat("t5_b2", 32'hA0A0_0002, 1'b1, 2'b00, 1'b1);
    chk("t5_req_ready", req_ready, 1);
    chk("t5_rready", RREADY, 0);

    // Missing RLAST on a single-beat read, then late RLAST
    issue(1'b0, 32'h0000_6000, 4'd0, 32'd0, 4'd0);
    ar_accept(32'h0000_6000, 4'd0);
    beat("t7_b0", 32'h6666_0000, 1'b0, 2'b00, 1'b1);
    chk("t7_still_busy", RREADY, 1);
    beat("t7_b1", 32'h6666_0001, 1'b1, 2'b00, 1'b1);
    chk("t7_req_ready", req_ready, 1);

    // Asynchronous reset in the middle of a burst
    issue(1'b0, 32'h0000_5000, 4'd3, 32'd0, 4'd0);
    ar_accept(32'h0000_5000, 4'd3);
    beat("t6_b0", 32'h5555_0000, 1'b0, 2'b00, 1'b0);
    #2 ARESETn = 1'b0;
    #1;
    chk("t6_rst_req_ready", req_ready, 1);
    chk("t6_rst_rready", RREADY, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    chk("t6_rst_rsp_data", rsp_data, 0);
    chk("t6_rst_araddr", ARADDR, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("t6_no_completion", rsp_valid, 0);
    issue(1'b0, 32'h0000_7000, 4'd1, 32'd0, 4'd0);
    ar_accept(32'h0000_7000, 4'd1);
    beat("t6_n0", 32'h7777_0000, 1'b0, 2'b00, 1'b0);
    beat("t6_n1", 32'h7777_0001, 1'b1, 2'b00, 1'b0);
    chk("t6_req_ready", req_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
